// File: rtl/i2c_cmd_sequencer_pkg.sv
// i2c_cmd_sequencer shared types.
// Command packing and sequencer FSM states.
package i2c_cmd_sequencer_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  localparam int CMD_W      = 16;

  typedef struct packed {
    logic [I2C_ADDR_W-1:0] addr;
    logic                  rw;
    logic [I2C_DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_LAUNCH,
    SEQ_WAIT_DONE,
    SEQ_CAPTURE
  } seq_state_t;

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Host-side command / response handshake bundle.
// slave = sequencer side, master = host side.
interface i2c_cmd_sequencer_if;
  import i2c_cmd_sequencer_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [I2C_ADDR_W-1:0] cmd_addr;
  logic                  cmd_rw;
  logic [I2C_DATA_W-1:0] cmd_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [I2C_DATA_W-1:0] rsp_data;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_rw,
    input  cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_rw,
    output cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/i2c_cmd_sequencer_fifo.sv
// Registered first-word-fall-through FIFO.
// Pointers carry one extra wrap bit.
module i2c_cmd_sequencer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign level   = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Host command queue feeding an I2C master.
// Launches one command at a time, paced by ready.
module i2c_cmd_sequencer
  import i2c_cmd_sequencer_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  i2c_cmd_sequencer_if.slave      host,
  output logic [I2C_ADDR_W-1:0]   m_addr,
  output logic                    m_rw,
  output logic [I2C_DATA_W-1:0]   m_data,
  output logic                    m_enable,
  input  logic                    m_ready,
  input  logic [I2C_DATA_W-1:0]   m_data_out,
  output logic                    busy,
  output logic                    timeout_err,
  input  logic                    err_clr,
  output logic [$clog2(CMD_DEPTH):0] cmd_level
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT_CYCLES - 1);

  seq_state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic       rdy_s;
  logic [WD_W-1:0] wd;
  logic       wd_hit;
  logic       cmd_pop, rsp_push;
  logic       en_n, wd_clr, abort;
  logic       cmd_empty, cmd_full;
  logic       rsp_empty, rsp_full;
  logic [CMD_W-1:0] cmd_rd;
  cmd_t       cmd_head;
  logic [$clog2(RSP_DEPTH):0] rsp_level;

  i2c_cmd_sequencer_fifo #(
    .WIDTH(CMD_W), .DEPTH(CMD_DEPTH)
  ) u_cmd_fifo (
    .clk(clk), .rst(rst),
    .push(host.cmd_valid),
    .push_data({host.cmd_addr, host.cmd_rw,
                host.cmd_data}),
    .pop(cmd_pop),
    .pop_data(cmd_rd),
    .level(cmd_level)
  );

  i2c_cmd_sequencer_fifo #(
    .WIDTH(I2C_DATA_W), .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk(clk), .rst(rst),
    .push(rsp_push),
    .push_data(m_data_out),
    .pop(host.rsp_ready),
    .pop_data(host.rsp_data),
    .level(rsp_level)
  );

  assign cmd_head  = cmd_t'(cmd_rd);
  assign cmd_empty = (cmd_level == '0);
  assign cmd_full  = (cmd_level == CMD_DEPTH);
  assign rsp_empty = (rsp_level == '0);
  assign rsp_full  = (rsp_level == RSP_DEPTH);

  assign host.cmd_ready = ~cmd_full;
  assign host.rsp_valid = ~rsp_empty;
  assign busy   = (state != SEQ_IDLE) | ~cmd_empty;
  assign rdy_s  = sync_q[SYNC_STAGES-1];
  assign wd_hit = (wd == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= m_ready;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    state_n  = state;
    cmd_pop  = 1'b0;
    rsp_push = 1'b0;
    en_n     = m_enable;
    wd_clr   = 1'b0;
    abort    = 1'b0;
    unique case (state)
      SEQ_IDLE: begin
        // reads wait for guaranteed response space
        if (!cmd_empty && rdy_s &&
            !(cmd_head.rw && rsp_full)) begin
          cmd_pop = 1'b1;
          en_n    = 1'b1;
          wd_clr  = 1'b1;
          state_n = SEQ_LAUNCH;
        end
      end
      SEQ_LAUNCH: begin
        if (wd_hit) begin
          abort = 1'b1;
        end else if (!rdy_s) begin
          en_n    = 1'b0;
          wd_clr  = 1'b1;
          state_n = SEQ_WAIT_DONE;
        end
      end
      SEQ_WAIT_DONE: begin
        if (wd_hit) begin
          abort = 1'b1;
        end else if (rdy_s) begin
          state_n = m_rw ? SEQ_CAPTURE : SEQ_IDLE;
        end
      end
      SEQ_CAPTURE: begin
        rsp_push = 1'b1;
        state_n  = SEQ_IDLE;
      end
    endcase
    if (abort) begin
      en_n    = 1'b0;
      state_n = SEQ_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEQ_IDLE;
      m_addr      <= '0;
      m_rw        <= 1'b0;
      m_data      <= '0;
      m_enable    <= 1'b0;
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_n;
      m_enable <= en_n;
      if (cmd_pop) begin
        m_addr <= cmd_head.addr;
        m_rw   <= cmd_head.rw;
        m_data <= cmd_head.data;
      end
      if (wd_clr)
        wd <= '0;
      else if (state == SEQ_LAUNCH ||
               state == SEQ_WAIT_DONE)
        wd <= wd + 1'b1;
      if (abort)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer.
// Behavioural master model stands in for the I2C master.
module tb_i2c_cmd_sequencer;
  import i2c_cmd_sequencer_pkg::*;

  localparam int TO   = 64;
  localparam int BUSY = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] m_addr;
  logic       m_rw;
  logic [7:0] m_data;
  logic       m_enable;
  logic       m_ready;
  logic [7:0] m_data_out;
  logic       busy;
  logic       timeout_err;
  logic       err_clr = 1'b0;
  logic [2:0] cmd_level;

  bit   stub = 1'b0;
  int   cnt;
  logic [6:0] cur_a;
  logic       cur_rw;
  logic [15:0] log_q[$];

  int n_chk = 0;
  int n_bad = 0;
  int base;

  i2c_cmd_sequencer_if hif();

  i2c_cmd_sequencer #(
    .CMD_DEPTH(4), .RSP_DEPTH(2),
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .host(hif),
    .m_addr(m_addr), .m_rw(m_rw),
    .m_data(m_data), .m_enable(m_enable),
    .m_ready(m_ready), .m_data_out(m_data_out),
    .busy(busy), .timeout_err(timeout_err),
    .err_clr(err_clr), .cmd_level(cmd_level)
  );

  always #5 clk = ~clk;

  // master: accepts on enable, busy BUSY+1 clocks
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready    <= 1'b1;
      cnt        <= 0;
      m_data_out <= 8'h00;
    end else if (stub) begin
      m_ready <= 1'b1;
    end else if (m_ready) begin
      if (m_enable) begin
        m_ready <= 1'b0;
        cnt     <= BUSY;
        cur_a   <= m_addr;
        cur_rw  <= m_rw;
        log_q.push_back({m_addr, m_rw, m_data});
      end
    end else if (cnt == 0) begin
      m_ready    <= 1'b1;
      m_data_out <= (cur_rw && cur_a == 7'h2A) ?
                    8'hCC : 8'h00;
    end else begin
      cnt <= cnt - 1;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit cond(input int w);
    case (w)
      0:       return busy == 1'b0;
      1:       return hif.rsp_valid == 1'b1;
      2:       return m_enable == 1'b1;
      default: return m_enable == 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int w, input int max,
                          input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      if (cond(w)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic drive(input logic [6:0] a,
                       input logic rw,
                       input logic [7:0] d);
    hif.cmd_valid = 1'b1;
    hif.cmd_addr  = a;
    hif.cmd_rw    = rw;
    hif.cmd_data  = d;
    step(1);
    hif.cmd_valid = 1'b0;
  endtask

  task automatic pop(input string tag,
                     input logic [7:0] exp);
    check(tag, 32'(hif.rsp_valid), 32'd1);
    check(tag, 32'(hif.rsp_data), 32'(exp));
    hif.rsp_ready = 1'b1;
    step(1);
    hif.rsp_ready = 1'b0;
  endtask

  logic [15:0] burst [5];

  initial begin
    hif.cmd_valid = 1'b0;
    hif.cmd_addr  = '0;
    hif.cmd_rw    = 1'b0;
    hif.cmd_data  = '0;
    hif.rsp_ready = 1'b0;
    step(3);
    check("rst_en", 32'(m_enable), 0);
    check("rst_rdy", 32'(hif.cmd_ready), 1);
    rst = 1'b0;
    #1;
    check("rst_rsp", 32'(hif.rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_lvl", 32'(cmd_level), 0);
    check("rst_err", 32'(timeout_err), 0);
    check("rst_addr", 32'(m_addr), 0);
    step(4);

    // single write with exact launch latency
    base = log_q.size();
    drive(7'h2A, 1'b0, 8'h5A);
    check("w_en0", 32'(m_enable), 0);
    check("w_lvl1", 32'(cmd_level), 1);
    check("w_busy", 32'(busy), 1);
    step(1);
    check("w_en1", 32'(m_enable), 1);
    check("w_addr", 32'(m_addr), 32'h2A);
    check("w_rw", 32'(m_rw), 0);
    check("w_data", 32'(m_data), 32'h5A);
    check("w_lvl0", 32'(cmd_level), 0);
    wait_for(0, 200, "w_done");
    check("w_frames", log_q.size() - base, 1);
    check("w_log", 32'(log_q[base]), 32'h545A);
    check("w_rsp", 32'(hif.rsp_valid), 0);
    check("w_en_off", 32'(m_enable), 0);
    check("w_hold", 32'(m_addr), 32'h2A);

    // single read
    base = log_q.size();
    drive(7'h2A, 1'b1, 8'h00);
    wait_for(1, 200, "r_rsp");
    pop("r_pop", 8'hCC);
    check("r_empty", 32'(hif.rsp_valid), 0);
    check("r_frames", log_q.size() - base, 1);

    // back-to-back burst W,W,R,W,R fills queue
    burst[0] = {7'h2A, 1'b0, 8'h11};
    burst[1] = {7'h2A, 1'b0, 8'h22};
    burst[2] = {7'h2A, 1'b1, 8'h00};
    burst[3] = {7'h2A, 1'b0, 8'h33};
    burst[4] = {7'h2A, 1'b1, 8'h00};
    base = log_q.size();
    for (int i = 0; i < 5; i++) begin
      check("q_rdy", 32'(hif.cmd_ready), 1);
      hif.cmd_valid = 1'b1;
      {hif.cmd_addr, hif.cmd_rw, hif.cmd_data} =
        burst[i];
      step(1);
    end
    hif.cmd_valid = 1'b0;
    check("q_full", 32'(hif.cmd_ready), 0);
    check("q_lvl", 32'(cmd_level), 4);
    wait_for(0, 400, "q_done");
    check("q_frames", log_q.size() - base, 5);
    for (int i = 0; i < 5; i++)
      check("q_order", 32'(log_q[base+i]),
            32'(burst[i]));
    pop("q_pop0", 8'hCC);
    pop("q_pop1", 8'hCC);
    check("q_empty", 32'(hif.rsp_valid), 0);

    // response FIFO full stalls third read
    base = log_q.size();
    for (int i = 0; i < 3; i++) begin
      hif.cmd_valid = 1'b1;
      hif.cmd_addr  = 7'h2A;
      hif.cmd_rw    = 1'b1;
      hif.cmd_data  = 8'h00;
      step(1);
    end
    hif.cmd_valid = 1'b0;
    step(150);
    check("f_frames", log_q.size() - base, 2);
    check("f_en", 32'(m_enable), 0);
    check("f_lvl", 32'(cmd_level), 1);
    check("f_busy", 32'(busy), 1);
    pop("f_pop0", 8'hCC);
    wait_for(2, 20, "f_launch");
    wait_for(0, 200, "f_done");
    check("f_frames3", log_q.size() - base, 3);
    pop("f_pop1", 8'hCC);
    pop("f_pop2", 8'hCC);
    check("f_empty", 32'(hif.rsp_valid), 0);

    // watchdog with master stuck ready
    stub = 1'b1;
    step(2);
    drive(7'h2A, 1'b0, 8'hA5);
    step(TO);
    check("t_err0", 32'(timeout_err), 0);
    check("t_en1", 32'(m_enable), 1);
    step(1);
    check("t_err1", 32'(timeout_err), 1);
    check("t_en0", 32'(m_enable), 0);
    check("t_busy", 32'(busy), 0);
    check("t_rsp", 32'(hif.rsp_valid), 0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t_clr", 32'(timeout_err), 0);
    stub = 1'b0;
    step(2);

    // reset during WAIT_DONE of a read
    base = log_q.size();
    drive(7'h2A, 1'b1, 8'h00);
    wait_for(2, 20, "x_launch");
    wait_for(3, 20, "x_wait");
    drive(7'h2A, 1'b0, 8'h77);
    check("x_lvl", 32'(cmd_level), 1);
    rst = 1'b1;
    #1;
    check("x_en", 32'(m_enable), 0);
    check("x_addr", 32'(m_addr), 0);
    check("x_rw", 32'(m_rw), 0);
    check("x_busy", 32'(busy), 0);
    check("x_lvl0", 32'(cmd_level), 0);
    check("x_rdy", 32'(hif.cmd_ready), 1);
    check("x_rsp", 32'(hif.rsp_valid), 0);
    step(1);
    rst = 1'b0;
    step(40);
    check("x_frames", log_q.size() - base, 1);
    check("x_rsp2", 32'(hif.rsp_valid), 0);
    drive(7'h2A, 1'b1, 8'h00);
    wait_for(1, 200, "x_rsp3");
    pop("x_pop", 8'hCC);

    $display("test done: total=%0d bad=%0d",
             n_chk, n_bad);
    $finish;
  end

endmodule
